// File: rtl/fal6567_clksel_if.sv
// Signal bundle between the video clock sequencer and the rest of the clocking domain.
// The controller connects through the slave modport; the environment drives through master.
interface fal6567_clksel_if;
    logic       locked;
    logic       turbo_req;
    logic       dcrate_req;
    logic       quiesce_ack;
    logic       mmcm_rst;
    logic       turbo2;
    logic       dcrate;
    logic       quiesce_req;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic [7:0] lock_loss_cnt;

    modport master (
        output locked, turbo_req, dcrate_req, quiesce_ack,
        input  mmcm_rst, turbo2, dcrate, quiesce_req, sys_rst, ready, fail, lock_loss_cnt
    );

    modport slave (
        input  locked, turbo_req, dcrate_req, quiesce_ack,
        output mmcm_rst, turbo2, dcrate, quiesce_req, sys_rst, ready, fail, lock_loss_cnt
    );
endinterface

// File: rtl/fal6567_clksel_ctrl.sv
// Video clock sequencer: MMCM reset/lock supervision and quiesced turbo2/dcrate BUFGMUX switching.
// Optional lock-loss counter enabled by defining FAL6567_CLKSEL_LOSSCNT_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// MRST    | MMCM held in reset for RST_CYCLES
// WLOCK   | waiting for synchronised lock, timeout -> retry or FAIL
// SETTLE  | clocks stabilising for SETTLE_CYCLES before release
// RUN     | clocks valid, downstream released
// QUIESCE | rate change pending, waiting for downstream to stop
// SWITCH  | one cycle, select lines take the requested levels
// FAIL    | lock never achieved, sticky until rst
module fal6567_clksel_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4095,
    parameter int MAX_RETRY     = 3,
    parameter int SETTLE_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    fal6567_clksel_if.slave  cs
);

    localparam int CW = 12;
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [CW-1:0] RST_TC    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_TC   = CW'(LOCK_TIMEOUT);
    localparam logic [CW-1:0] SETTLE_TC = CW'(SETTLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        MRST, WLOCK, SETTLE, RUN, QUIESCE, SWITCH, FAIL
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    lock_sync;
    logic          locked_s;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [RW-1:0] retry, retry_nxt, retry_inc;
    logic          turbo2_q, turbo2_nxt;
    logic          dcrate_q, dcrate_nxt;
    logic          quiesce_q, quiesce_nxt;
    logic          sys_rst_q, sys_rst_nxt;
    logic          mmcm_rst_q, ready_q, fail_q;

    assign locked_s  = lock_sync[1];
    assign retry_inc = retry + RW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_sync  <= 2'b00;
            state      <= MRST;
            cnt        <= '0;
            retry      <= '0;
            turbo2_q   <= 1'b0;
            dcrate_q   <= 1'b0;
            quiesce_q  <= 1'b0;
            sys_rst_q  <= 1'b1;
            mmcm_rst_q <= 1'b1;
            ready_q    <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            lock_sync  <= {lock_sync[0], cs.locked};
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            retry      <= retry_nxt;
            turbo2_q   <= turbo2_nxt;
            dcrate_q   <= dcrate_nxt;
            quiesce_q  <= quiesce_nxt;
            sys_rst_q  <= sys_rst_nxt;
            mmcm_rst_q <= (state_nxt == MRST);
            ready_q    <= (state_nxt == RUN);
            fail_q     <= (state_nxt == FAIL);
        end
    end

    // The shared timer restarts from zero on every state change.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = '0;
        retry_nxt   = retry;
        turbo2_nxt  = turbo2_q;
        dcrate_nxt  = dcrate_q;
        quiesce_nxt = quiesce_q;
        sys_rst_nxt = sys_rst_q;
        unique case (state)
            MRST: begin
                if (cnt == RST_TC) state_nxt = WLOCK;
                else               cnt_nxt   = cnt + CW'(1);
            end
            WLOCK: begin
                if (locked_s) begin
                    state_nxt = SETTLE;
                end else if (cnt == LOCK_TC) begin
                    retry_nxt = retry_inc;
                    state_nxt = (retry_inc == RETRY_MAX) ? FAIL : MRST;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            SETTLE: begin
                if (!locked_s) begin
                    state_nxt = MRST;
                end else if (cnt == SETTLE_TC) begin
                    state_nxt = RUN;
                    retry_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            RUN: begin
                if (!locked_s)
                    state_nxt = MRST;
                else if ((cs.turbo_req != turbo2_q) || (cs.dcrate_req != dcrate_q))
                    state_nxt = QUIESCE;
            end
            QUIESCE: begin
                // Lock loss wins over a completed handshake.
                if (!locked_s)          state_nxt = MRST;
                else if (cs.quiesce_ack) state_nxt = SWITCH;
            end
            SWITCH: begin
                turbo2_nxt = cs.turbo_req;
                dcrate_nxt = cs.dcrate_req;
                state_nxt  = SETTLE;
            end
            FAIL: state_nxt = FAIL;
            default: state_nxt = MRST;
        endcase

        unique case (state_nxt)
            MRST, FAIL: begin
                quiesce_nxt = 1'b0;
                sys_rst_nxt = 1'b1;
            end
            RUN: begin
                quiesce_nxt = 1'b0;
                sys_rst_nxt = 1'b0;
            end
            QUIESCE: quiesce_nxt = 1'b1;
            default: ;
        endcase
    end

    assign cs.mmcm_rst    = mmcm_rst_q;
    assign cs.turbo2      = turbo2_q;
    assign cs.dcrate      = dcrate_q;
    assign cs.quiesce_req = quiesce_q;
    assign cs.sys_rst     = sys_rst_q;
    assign cs.ready       = ready_q;
    assign cs.fail        = fail_q;

`ifdef FAL6567_CLKSEL_LOSSCNT_EN
    logic [7:0] loss_cnt;
    logic       loss_evt;

    assign loss_evt = (state == RUN) && !locked_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            loss_cnt <= '0;
        else if (loss_evt && (loss_cnt != 8'hFF))
            loss_cnt <= loss_cnt + 8'd1;
    end

    assign cs.lock_loss_cnt = loss_cnt;
`else
    assign cs.lock_loss_cnt = 8'd0;
`endif

endmodule
